// File: rtl/ql_vram_ctrl.sv
// QL screen-memory controller: 32K x 16 dual-port BRAM with a read-only video port and
// an 8-bit CPU port (req/ack handshake), plus the MC display-control register.
module ql_vram_ctrl #(
   parameter logic [19:0] SCR_BASE  = 20'h20000,
   parameter logic [19:0] MC_ADDR   = 20'h18063,
   parameter              INIT_FILE = ""
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [19:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_din,
   input  logic        i_cpu_rd,
   input  logic        i_cpu_wr,
   output logic [7:0]  o_cpu_dout,
   output logic        o_cpu_sel,
   output logic        o_cpu_ack,
   input  logic [13:0] i_vid_addr,
   output logic [15:0] o_vid_dout,
   output logic        o_mode,
   output logic        o_blank,
   output logic        o_page
);

   typedef enum logic [1:0] {IDLE, ACC, ACK, REL} state_t;

   state_t      r_state;
   logic [15:0] r_mem [0:32767];
   logic [15:0] r_cpuWord;
   logic [15:0] r_vidDout;
   logic [7:0]  r_cpuDout;
   logic [7:0]  r_mc;
   logic        r_cpuAck;
   logic        r_isRead;

   logic        w_scrHit;
   logic        w_mcHit;
   logic        w_sel;
   logic        w_memWr;
   logic [14:0] w_wordAddr;
   logic [14:0] w_vidAddr;

   assign w_scrHit   = (i_cpu_addr[19:16] == SCR_BASE[19:16]);
   assign w_mcHit    = (i_cpu_addr == MC_ADDR);
   assign w_sel      = w_scrHit | w_mcHit;
   assign w_wordAddr = i_cpu_addr[15:1];
   assign w_vidAddr  = {r_mc[7], i_vid_addr};
   assign w_memWr    = (r_state == IDLE) && w_scrHit && !w_mcHit && i_cpu_wr && !i_reset;

   // Port B: big-endian byte-lane writes, and a free-running word read that the FSM picks up in ACC
   always_ff @(posedge i_clk) begin
      if (w_memWr && !i_cpu_addr[0]) r_mem[w_wordAddr][15:8] <= i_cpu_din;
      if (w_memWr && i_cpu_addr[0])  r_mem[w_wordAddr][7:0]  <= i_cpu_din;
      r_cpuWord <= r_mem[w_wordAddr];
   end

   // Port A: read-first, so a same-cycle CPU write shows up only on the following read
   always_ff @(posedge i_clk) begin
      if (i_reset) r_vidDout <= '0;
      else         r_vidDout <= r_mem[w_vidAddr];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_cpuAck  <= 1'b0;
         r_cpuDout <= '0;
         r_mc      <= '0;
         r_isRead  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cpuAck <= 1'b0;
               if (w_sel && i_cpu_wr) begin
                  if (w_mcHit) r_mc <= i_cpu_din;
                  r_isRead <= 1'b0;
                  r_state  <= ACC;
               end else if (w_sel && i_cpu_rd) begin
                  r_isRead <= 1'b1;
                  r_state  <= ACC;
               end
            end
            ACC: begin
               if (!i_cpu_rd && !i_cpu_wr) begin
                  r_state <= IDLE;
               end else begin
                  if (r_isRead)
                     r_cpuDout <= w_mcHit ? r_mc :
                                  (i_cpu_addr[0] ? r_cpuWord[7:0] : r_cpuWord[15:8]);
                  r_cpuAck <= 1'b1;
                  r_state  <= ACK;
               end
            end
            ACK: begin
               r_cpuAck <= 1'b0;
               r_state  <= REL;
            end
            REL: begin
               // Hold here until the strobe drops so one assertion yields exactly one ack
               if (!i_cpu_rd && !i_cpu_wr) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_cpu_sel  = w_sel;
   assign o_cpu_ack  = r_cpuAck;
   assign o_cpu_dout = r_cpuDout;
   assign o_vid_dout = r_vidDout;
   assign o_mode     = r_mc[3];
   assign o_blank    = r_mc[1];
   assign o_page     = r_mc[7];

endmodule
